csr_wport_arbiter: RTL

Shares the single CSR write port between two requesters. The first is the WB-stage CSR-instruction writer (single writes, valid/ready). The second is the trap sequencer (multi-beat bursts such as mepc/mcause/mtval/mstatus/mip). The block buffers WB writes in a small FIFO and guarantees program order: every WB write accepted before a trap request commits before the first trap beat. A trap burst, once granted, owns the port until its last beat.

---
 rtl/csr_wport_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/csr_wport_arbiter.sv
// csr_wport_arbiter: shares the single CSR write port between the WB-stage CSR writer and the
// trap sequencer. WB writes are buffered in a small FIFO and always drained before a trap burst
// is granted. A granted burst owns the port until its last beat.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   wb_valid_i/wb_ready_o       WB write handshake, wb_addr_i/wb_data_i payload
//   trap_req_i/trap_gnt_o       trap beat handshake (req held for whole burst)
//   trap_addr_i/trap_data_i     trap beat payload, trap_last_i marks final beat
//   csr_write_*_o               registered CSR write port
//   busy_o                      burst in progress or FIFO non-empty
//   fifo_count_o                registered WB FIFO occupancy
//   proto_err_o                 sticky: trap_req_i dropped mid-burst without last
module csr_wport_arbiter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid_i,
  output logic             wb_ready_o,
  input  logic [11:0]      wb_addr_i,
  input  logic [31:0]      wb_data_i,
  input  logic             trap_req_i,
  output logic             trap_gnt_o,
  input  logic [11:0]      trap_addr_i,
  input  logic [31:0]      trap_data_i,
  input  logic             trap_last_i,
  output logic             csr_write_en_o,
  output logic [11:0]      csr_write_addr_o,
  output logic [31:0]      csr_write_data_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] fifo_count_o,
  output logic             proto_err_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_TRAP = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             err_set;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [11:0]      mem_addr [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic             enq, deq;

  // A pending trap request blocks new WB writes so everything already queued drains first.
  assign wb_ready_o   = (count_q < FULL_CNT) && !trap_req_i && (state_q != ST_TRAP);
  assign trap_gnt_o   = (state_q == ST_TRAP) && trap_req_i;
  assign enq          = wb_valid_i && wb_ready_o;
  assign deq          = (state_q == ST_IDLE) && (count_q != '0);
  assign busy_o       = (state_q == ST_TRAP) || (count_q != '0);
  assign fifo_count_o = count_q;

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Grant only once the FIFO is empty: preserves program order.
        if (trap_req_i && (count_q == '0)) state_d = ST_TRAP;
      end
      ST_TRAP: begin
        if (!trap_req_i) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end else if (trap_last_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      proto_err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_set) proto_err_o <= 1'b1;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_addr[wr_ptr_q] <= wb_addr_i;
      mem_data[wr_ptr_q] <= wb_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Single registered write stage; addr/data hold when no write is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_write_en_o   <= 1'b0;
      csr_write_addr_o <= '0;
      csr_write_data_o <= '0;
    end else if (deq) begin
      csr_write_en_o   <= 1'b1;
      csr_write_addr_o <= mem_addr[rd_ptr_q];
      csr_write_data_o <= mem_data[rd_ptr_q];
    end else if (trap_gnt_o) begin
      csr_write_en_o   <= 1'b1;
      csr_write_addr_o <= trap_addr_i;
      csr_write_data_o <= trap_data_i;
    end else begin
      csr_write_en_o   <= 1'b0;
    end
  end

endmodule
